// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_pkg
//  Purpose  : Shared operation codes, FSM state encoding and helpers for the
//             HI/LO multiply/divide engine.
//  Contents : MD_WIDTH / MD_CNT_W defaults, md_op_e, md_state_e,
//             md_is_arith(), md_is_signed()
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Operations that run through the multi-cycle datapath.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // Operations whose operands are two's-complement.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_if
//  Purpose  : Request/result bundle between EX and the HI/LO engine.
//  Signals  : start, md_op[2:0], a, b, flush   (EX -> engine)
//             busy, done, hi, lo               (engine -> EX)
//  Modports : master (EX side), slave (engine side)
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit_md_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : md_div_step
//  Purpose  : One combinational restoring-division step. The next dividend
//             bit is shifted from the top of quo into rem; if the partial
//             remainder covers the divisor it is subtracted and a 1 enters
//             the quotient, else a 0 enters.
//  Ports    : rem_i, quo_i, div_i (in)  rem_o, quo_o (out)
//  Revision : 1.0  initial release
// ============================================================================
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem_i,
    input  wire logic [WIDTH-1:0] quo_i,
    input  wire logic [WIDTH-1:0] div_i,
    output logic      [WIDTH-1:0] rem_o,
    output logic      [WIDTH-1:0] quo_o
);
    logic [WIDTH:0]   w_part;
    logic [WIDTH-1:0] w_diff;

    assign w_part = {rem_i, quo_i[WIDTH-1]};
    // When the subtraction is taken the result is below the divisor, so the
    // low WIDTH bits are exact.
    assign w_diff = w_part[WIDTH-1:0] - div_i;

    always_comb begin
        rem_o = w_part[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (w_part >= {1'b0, div_i}) begin
            rem_o = w_diff;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO. Also
//             performs MTHI/MTLO in a single edge. Works on operand
//             magnitudes for 32 radix-2 steps, then applies the sign fix.
//  Ports    : clk, rst (sync, active-high)
//             md : muldiv_unit_if.slave (start, md_op, a, b, flush ->
//                  busy, done, hi, lo)
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    muldiv_unit_if.slave  md
);
    md_state_e        state_q, state_d;
    md_op_e           op_q;
    logic             sa_q, sb_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;   // product / {rem, quo}
    logic [WIDTH-1:0] bmag_q;               // multiplicand / divisor magnitude
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             w_req_signed;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic             w_is_mult;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_div_rem, w_div_quo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix, w_rem_fix;
    logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

    assign w_req_signed = md_is_signed(md.md_op);
    assign w_accept     = md.start && !md.flush && md_is_arith(md.md_op);
    assign w_a_mag      = (w_req_signed && md.a[WIDTH-1]) ? -md.a : md.a;
    assign w_b_mag      = (w_req_signed && md.b[WIDTH-1]) ? -md.b : md.b;
    assign w_is_mult    = (op_q == MD_MULT) || (op_q == MD_MULTU);

    // Shift-add: multiplier sits in acc_lo and is consumed LSB first while
    // the partial product grows into acc_hi.
    assign w_mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, bmag_q} : '0);

    md_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_hi_q),
        .quo_i (acc_lo_q),
        .div_i (bmag_q),
        .rem_o (w_div_rem),
        .quo_o (w_div_quo)
    );

    // Sign fix. A zero divisor yields rem=|a| from the restoring loop, so
    // re-applying the dividend sign restores the raw a for HI.
    assign w_prod_fix = (sa_q ^ sb_q) ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign w_quo_fix  = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
    assign w_rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;
    assign w_fix_hi   = w_is_mult ? w_prod_fix[2*WIDTH-1:WIDTH] : w_rem_fix;
    assign w_fix_lo   = w_is_mult ? w_prod_fix[WIDTH-1:0] :
                        ((bmag_q == '0) ? '1 : w_quo_fix);

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (w_accept) state_d = MD_CALC;
            MD_CALC: begin
                if (md.flush)
                    state_d = MD_IDLE;
                else if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = MD_FIX;
            end
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= MD_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= MD_NONE;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            bmag_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (w_accept) begin
                        op_q     <= md_op_e'(md.md_op);
                        sa_q     <= w_req_signed && md.a[WIDTH-1];
                        sb_q     <= w_req_signed && md.b[WIDTH-1];
                        acc_hi_q <= '0;
                        acc_lo_q <= w_a_mag;
                        bmag_q   <= w_b_mag;
                        cnt_q    <= '0;
                    end else if (md.start && !md.flush) begin
                        if (md.md_op == MD_MTHI) hi_q <= md.a;
                        if (md.md_op == MD_MTLO) lo_q <= md.a;
                    end
                end
                MD_CALC: begin
                    if (!md.flush) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (w_is_mult) begin
                            {acc_hi_q, acc_lo_q} <= {w_mul_sum, acc_lo_q[WIDTH-1:1]};
                        end else begin
                            acc_hi_q <= w_div_rem;
                            acc_lo_q <= w_div_quo;
                        end
                    end
                end
                MD_FIX: begin
                    if (!md.flush) begin
                        hi_q   <= w_fix_hi;
                        lo_q   <= w_fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md.busy = (state_q != MD_IDLE);
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit. Stimulus pushes expected
//             {hi,lo} into a queue; a monitor pops and compares on done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) md_if ();

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md_if)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && md_if.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 hi=0x%08h lo=0x%08h expected no done",
                         md_if.hi, md_if.lo);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_hi", md_if.hi, mon_e[63:32]);
                check("sb_lo", md_if.lo, mon_e[31:0]);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of the done cycle.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int cnt;
        exp_q.push_back({eh, el});
        md_if.start = 1'b1;
        md_if.md_op = op;
        md_if.a     = a;
        md_if.b     = b;
        @(negedge clk);
        md_if.start = 1'b0;
        md_if.md_op = MD_NONE;
        cnt = 0;
        while (md_if.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(cnt), 32'd33);
        check({name, "_done"}, 32'(md_if.done), 32'd1);
    endtask

    task automatic single(input logic [2:0] op, input logic [31:0] a);
        md_if.start = 1'b1;
        md_if.md_op = op;
        md_if.a     = a;
        @(negedge clk);
        md_if.start = 1'b0;
        md_if.md_op = MD_NONE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        md_if.start = 1'b0;
        md_if.md_op = MD_NONE;
        md_if.a     = '0;
        md_if.b     = '0;
        md_if.flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_hi",   md_if.hi, 32'h0);
        check("rst_lo",   md_if.lo, 32'h0);
        check("rst_busy", 32'(md_if.busy), 32'h0);
        check("rst_done", 32'(md_if.done), 32'h0);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        check("done_one_cycle", 32'(md_if.done), 32'h0);

        run_op("mult_m3x7",   MD_MULT, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // Back-to-back: each following op starts in the done cycle.
        run_op("mult_minsq",  MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_m7d2",    MD_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7d2",    MD_DIVU, 32'd7,         32'd2,        32'd1,         32'd3);
        run_op("div_100dm7",  MD_DIV,  32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2);
        run_op("div_m100dm7", MD_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);
        run_op("divu_by0",    MD_DIVU, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_neg_by0", MD_DIV,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",     MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);

        single(MD_MTHI, 32'hA5A5_A5A5);
        check("mthi_hi",   md_if.hi, 32'hA5A5_A5A5);
        check("mthi_busy", 32'(md_if.busy), 32'h0);
        check("mthi_done", 32'(md_if.done), 32'h0);
        single(MD_MTLO, 32'h5A5A_5A5A);
        check("mtlo_lo",   md_if.lo, 32'h5A5A_5A5A);
        check("mtlo_hi",   md_if.hi, 32'hA5A5_A5A5);
        check("mtlo_busy", 32'(md_if.busy), 32'h0);

        md_if.flush = 1'b1;
        single(MD_MTHI, 32'h1111_1111);
        md_if.flush = 1'b0;
        check("flush_mthi_hi", md_if.hi, 32'hA5A5_A5A5);

        single(MD_RSVD, 32'h2222_2222);
        check("rsvd_busy", 32'(md_if.busy), 32'h0);
        check("rsvd_hi",   md_if.hi, 32'hA5A5_A5A5);
        single(MD_NONE, 32'h3333_3333);
        check("none_busy", 32'(md_if.busy), 32'h0);

        // Flush mid-operation.
        md_if.b = 32'd6;
        single(MD_MULT, 32'd5);
        check("flush_started_busy", 32'(md_if.busy), 32'h1);
        repeat (9) @(negedge clk);
        md_if.flush = 1'b1;
        @(negedge clk);
        md_if.flush = 1'b0;
        check("flush_busy", 32'(md_if.busy), 32'h0);
        check("flush_hi",   md_if.hi, 32'hA5A5_A5A5);
        check("flush_lo",   md_if.lo, 32'h5A5A_5A5A);
        repeat (40) @(negedge clk);
        check("flush_hi_late", md_if.hi, 32'hA5A5_A5A5);
        check("flush_lo_late", md_if.lo, 32'h5A5A_5A5A);

        // Reset mid-operation.
        single(MD_MULT, 32'd5);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(md_if.busy), 32'h0);
        check("rst_mid_hi",   md_if.hi, 32'h0);
        check("rst_mid_lo",   md_if.lo, 32'h0);
        repeat (40) @(negedge clk);
        check("rst_mid_lo_late", md_if.lo, 32'h0);

        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
